// File: rtl/fifo_stream_out_if.sv
// Stream side of the FIFO drain stage: a plain valid/ready word stream.
// A word transfers on a rising Clock edge where Out_valid && Out_ready; while Out_valid is high and Out_ready low, Out_valid and Out_data hold.
interface fifo_stream_out_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Out_valid;
    logic                  Out_ready;
    logic [DATA_WIDTH-1:0] Out_data;

    modport master (
        output Out_valid,
        output Out_data,
        input  Out_ready
    );

    modport slave (
        input  Out_valid,
        input  Out_data,
        output Out_ready
    );
endinterface

// File: rtl/fifo_stream_out.sv
// Drains a synchronous FIFO (1-cycle read latency) into a valid/ready stream
// through a 3-entry skid buffer, with flush, transfer counter and overflow flag.
module fifo_stream_out #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  Clock,
    input  logic                  Fifo_rst,
    input  logic                  Fifo_empty,
    output logic                  Fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] Fifo_rd_data,
    input  logic                  Flush,
    fifo_stream_out_if.master     out_if,
    output logic [CNT_WIDTH-1:0]  Xfer_count,
    output logic                  Overflow_err
);

    logic [DATA_WIDTH-1:0] buf_mem [3];
    logic [1:0]            head;
    logic [1:0]            tail;
    logic [1:0]            occ;
    logic                  inflight;
    logic                  push;
    logic                  pop;
    logic                  wr_ok;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Read only when the word can be guaranteed a slot: occ + inflight never exceeds 3.
    // Out_ready is deliberately absent so there is no combinational ready-to-read path.
    assign Fifo_rd_en = !Fifo_rst && !Fifo_empty && !Flush &&
                        (({1'b0, occ} + {2'b00, inflight}) <= 3'd2);

    assign pop   = out_if.Out_valid && out_if.Out_ready;
    assign push  = inflight && !Flush;
    assign wr_ok = push && ((occ != 2'd3) || pop);

    assign out_if.Out_valid = (occ != 2'd0);
    assign out_if.Out_data  = buf_mem[head];

    always_ff @(posedge Clock or posedge Fifo_rst) begin
        if (Fifo_rst) begin
            for (int i = 0; i < 3; i++) buf_mem[i] <= '0;
            head         <= 2'd0;
            tail         <= 2'd0;
            occ          <= 2'd0;
            inflight     <= 1'b0;
            Xfer_count   <= '0;
            Overflow_err <= 1'b0;
        end else begin
            inflight <= Fifo_rd_en;
            // A handshake in the flush cycle still counts.
            if (pop) Xfer_count <= Xfer_count + 1'b1;
            if (Flush) begin
                head <= 2'd0;
                tail <= 2'd0;
                occ  <= 2'd0;
            end else begin
                if (push && !wr_ok) Overflow_err <= 1'b1;
                if (wr_ok) begin
                    buf_mem[tail] <= Fifo_rd_data;
                    tail          <= next_ptr(tail);
                end
                if (pop) head <= next_ptr(head);
                case ({wr_ok, pop})
                    2'b10:   occ <= occ + 2'd1;
                    2'b01:   occ <= occ - 2'd1;
                    default: occ <= occ;
                endcase
            end
        end
    end

endmodule

// File: doc/fifo_stream_out.md
Name: fifo_stream_out

Overview:
- Drain stage directly downstream of the synchronous FIFO. Reads words from the FIFO read port and presents them on a valid/ready stream interface.
- Absorbs the FIFO's 1-cycle registered read latency with a 3-entry skid buffer. This sustains 1 word/cycle with no combinational path from Out_ready to Fifo_rd_en.
- Provides a synchronous flush, a transfer counter and a sticky overflow sanity flag.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and stream data.
- CNT_WIDTH, 16, width of the transfer counter.

Ports:
- Clock  input  1  clock; all state updates on rising edge.
- Fifo_rst  input  1  reset, asynchronous, active-high.
- Fifo_empty  input  1  FIFO empty flag; 0 means at least one word is readable this cycle.
- Fifo_rd_en  output  1  FIFO read request; one word is popped per cycle in which it is high.
- Fifo_rd_data  input  DATA_WIDTH  FIFO read data; valid in the cycle after Fifo_rd_en.
- Flush  input  1  synchronous flush of buffer and in-flight read.
- Out_valid  output  1  stream data valid.
- Out_ready  input  1  stream sink ready.
- Out_data  output  DATA_WIDTH  stream data.
- Xfer_count  output  CNT_WIDTH  count of completed stream handshakes.
- Overflow_err  output  1  sticky: returned FIFO word found no free buffer slot.

Behaviour:
- State:
  - buf[0..2] DATA_WIDTH entries.
  - 2-bit head and tail pointers; both wrap from 2 to 0.
  - 2-bit occ (0..3).
  - 1-bit inflight = Fifo_rd_en registered.
  - Xfer_count and Overflow_err registers.
- Reset (Fifo_rst=1, async):
  - occ=0, head=tail=0, inflight=0, all buf entries 0.
  - Out_valid=0, Out_data=0, Fifo_rd_en=0, Xfer_count=0, Overflow_err=0.
- Fifo_rd_en = !Fifo_empty && !Flush && (occ + inflight <= 2).
  - Combinational from registered state, Fifo_empty and Flush only; never from Out_ready.
- Push: when inflight=1 and Flush=0, Fifo_rd_data is written to buf[tail], tail advances and occ increments.
- Pop: when Out_valid && Out_ready, head advances, occ decrements and Xfer_count increments.
- Simultaneous push and pop: occ unchanged; both pointers advance.
- Xfer_count wraps modulo 2^CNT_WIDTH, with no saturation.
- Out_valid = (occ != 0). Out_data = buf[head].
- While Out_valid=1 and Out_ready=0, Out_data and Out_valid hold stable.
- Latency:
  - Fifo_rd_en high in cycle N puts the data in the buffer at the end of N+1.
  - Out_valid is high in N+2.
  - Empty buffer to first output: 2 cycles after Fifo_empty falls.
- Throughput: with Fifo_empty=0 and Out_ready=1 held, steady state is occ=1, inflight=1, Fifo_rd_en=1, giving one word per cycle.
- Backpressure: with Out_ready=0, at most 3 words are read (occ+inflight capped at 3), then Fifo_rd_en stays 0.
- Flush=1 in cycle N:
  - Fifo_rd_en=0 in N.
  - A handshake in N still completes and is counted.
  - At the end of N: occ=0, head=tail=0, inflight=0. Any word returning in N is discarded.
  - Out_valid=0 in N+1. Xfer_count is otherwise unaffected.
  - Reads resume in N+1 if Fifo_empty=0 and Flush=0.
- Overflow_err: set when a push occurs with occ=3 and no simultaneous pop. The word is dropped and buffer state is unchanged. Cleared only by Fifo_rst. By construction this never fires; the bench asserts it stays 0.
- Fifo_empty is trusted as registered by the FIFO. This block never asserts Fifo_rd_en while Fifo_empty=1.
- Reset mid-stream: all state is cleared immediately. Words already popped from the FIFO are lost. Fifo_rd_en drops combinationally with the reset.

Test Plan:
- Reset: Fifo_rst high for 3 cycles while Fifo_empty=0 -> Fifo_rd_en=0, Out_valid=0, Xfer_count=0 throughout; first Fifo_rd_en in the first cycle after release.
- Single word: FIFO model holds 0xA5, Out_ready=1 -> Fifo_rd_en high in exactly one cycle N; Out_valid=1 with Out_data=0xA5 in N+2 only; Xfer_count=1.
- Streaming: 16 words 0x00..0x0F, Out_ready=1 -> after 2-cycle fill, 16 consecutive Out_valid cycles in order 0x00..0x0F; Xfer_count=16; Overflow_err=0.
- Backpressure: 8 words 0x10..0x17 queued, Out_ready=0 for 10 cycles -> Fifo_rd_en high exactly 3 cycles; Out_data holds 0x10; on Out_ready=1, 0x10..0x17 emerge in order with no gaps after the first.
- Flush: with occ=2 and inflight=1 (words 0x20,0x21,0x22), Flush pulsed 1 cycle, Out_ready=0 -> Out_valid=0 next cycle; 0x20..0x22 never appear; next FIFO word 0x23 is output; Xfer_count unchanged.
- Counter wrap: CNT_WIDTH=4, 17 transfers -> Xfer_count=1.
